// File: rtl/branch_pkg.sv
// Shared encodings for the decode-stage branch control unit.
package branch_pkg;

    localparam int FLAG_NONE = 0;
    localparam int FLAG_JR   = 1;
    localparam int FLAG_JALR = 2;
    localparam int FLAG_BEQ  = 3;
    localparam int FLAG_BNE  = 4;
    localparam int FLAG_J    = 5;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_STALL    = 2'd1,
        ST_REDIRECT = 2'd2
    } state_e;

endpackage

// File: rtl/branch_control_unit_if.sv
// ID-stage view of the branch control unit: decode/hazard inputs and PC/pipeline strobes.
interface branch_control_unit_if #(
    parameter int CANT_BITS_ADDR           = 11,
    parameter int CANT_BITS_FLAG_BRANCH    = 3,
    parameter int CANT_BITS_DIR_REGISTROS  = 5,
    parameter int CANT_BITS_CONTADOR       = 16
);
    logic                                i_enable_etapa;
    logic [CANT_BITS_FLAG_BRANCH-1:0]    i_flag_branch;
    logic                                i_branch_control;
    logic [CANT_BITS_ADDR-1:0]           i_branch_dir;
    logic [CANT_BITS_DIR_REGISTROS-1:0]  i_rs;
    logic [CANT_BITS_DIR_REGISTROS-1:0]  i_rt;
    logic                                i_ex_reg_write;
    logic                                i_ex_mem_read;
    logic [CANT_BITS_DIR_REGISTROS-1:0]  i_ex_rd;
    logic                                i_mem_mem_read;
    logic [CANT_BITS_DIR_REGISTROS-1:0]  i_mem_rd;

    logic                                o_pc_write;
    logic                                o_pc_src;
    logic [CANT_BITS_ADDR-1:0]           o_pc_branch_dir;
    logic                                o_stall;
    logic                                o_flush_if_id;
    logic                                o_bubble_id_ex;
    logic [CANT_BITS_CONTADOR-1:0]       o_cant_branches_taken;
    logic [CANT_BITS_CONTADOR-1:0]       o_cant_stall_cycles;

    modport slave (
        input  i_enable_etapa, i_flag_branch, i_branch_control, i_branch_dir,
               i_rs, i_rt, i_ex_reg_write, i_ex_mem_read, i_ex_rd,
               i_mem_mem_read, i_mem_rd,
        output o_pc_write, o_pc_src, o_pc_branch_dir, o_stall, o_flush_if_id,
               o_bubble_id_ex, o_cant_branches_taken, o_cant_stall_cycles
    );

    modport master (
        output i_enable_etapa, i_flag_branch, i_branch_control, i_branch_dir,
               i_rs, i_rt, i_ex_reg_write, i_ex_mem_read, i_ex_rd,
               i_mem_mem_read, i_mem_rd,
        input  o_pc_write, o_pc_src, o_pc_branch_dir, o_stall, o_flush_if_id,
               o_bubble_id_ex, o_cant_branches_taken, o_cant_stall_cycles
    );

endinterface

// File: rtl/branch_hazard_detector.sv
// Combinational stall need (0/1/2 cycles) for the branch operands in ID.
module branch_hazard_detector
    import branch_pkg::*;
#(
    parameter int CANT_BITS_FLAG_BRANCH   = 3,
    parameter int CANT_BITS_DIR_REGISTROS = 5
) (
    input  logic [CANT_BITS_FLAG_BRANCH-1:0]   i_flag_branch,
    input  logic [CANT_BITS_DIR_REGISTROS-1:0] i_rs,
    input  logic [CANT_BITS_DIR_REGISTROS-1:0] i_rt,
    input  logic                               i_ex_reg_write,
    input  logic                               i_ex_mem_read,
    input  logic [CANT_BITS_DIR_REGISTROS-1:0] i_ex_rd,
    input  logic                               i_mem_mem_read,
    input  logic [CANT_BITS_DIR_REGISTROS-1:0] i_mem_rd,
    output logic [1:0]                         o_need
);
    localparam int FW = CANT_BITS_FLAG_BRANCH;

    logic       use_rs, use_rt;
    logic [1:0] need_rs, need_rt;

    // Later checks override earlier ones, so the EX load case wins with 2.
    function automatic logic [1:0] need_of(input logic [CANT_BITS_DIR_REGISTROS-1:0] r);
        logic [1:0] n;
        n = 2'd0;
        if (r != '0) begin
            if (i_mem_mem_read && i_mem_rd == r)                    n = 2'd1;
            if (i_ex_reg_write && !i_ex_mem_read && i_ex_rd == r)   n = 2'd1;
            if (i_ex_mem_read && i_ex_rd == r)                      n = 2'd2;
        end
        return n;
    endfunction

    always_comb begin
        use_rt  = (i_flag_branch == FW'(FLAG_BEQ)) || (i_flag_branch == FW'(FLAG_BNE));
        use_rs  = use_rt || (i_flag_branch == FW'(FLAG_JR)) || (i_flag_branch == FW'(FLAG_JALR));
        need_rs = use_rs ? need_of(i_rs) : 2'd0;
        need_rt = use_rt ? need_of(i_rt) : 2'd0;
        o_need  = (need_rs > need_rt) ? need_rs : need_rt;
    end

endmodule

// File: rtl/branch_control_unit.sv
// Stalls the front end on branch operand hazards, then redirects the PC and kills the wrong path.
module branch_control_unit
    import branch_pkg::*;
#(
    parameter int CANT_BITS_ADDR          = 11,
    parameter int CANT_BITS_FLAG_BRANCH   = 3,
    parameter int CANT_BITS_DIR_REGISTROS = 5,
    parameter int CANT_BITS_CONTADOR      = 16
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    branch_control_unit_if.slave  bif
);
    localparam int CW = CANT_BITS_CONTADOR;

    state_e                     state_q, state_d;
    logic [1:0]                 cnt_q, cnt_d;
    logic [CANT_BITS_ADDR-1:0]  dir_q, dir_d;
    logic [CW-1:0]              taken_q, taken_d;
    logic [CW-1:0]              stalls_q, stalls_d;
    logic [1:0]                 need;
    logic                       pc_write, pc_src, stall, flush, bubble;

    branch_hazard_detector #(
        .CANT_BITS_FLAG_BRANCH   (CANT_BITS_FLAG_BRANCH),
        .CANT_BITS_DIR_REGISTROS (CANT_BITS_DIR_REGISTROS)
    ) u_hazard (
        .i_flag_branch  (bif.i_flag_branch),
        .i_rs           (bif.i_rs),
        .i_rt           (bif.i_rt),
        .i_ex_reg_write (bif.i_ex_reg_write),
        .i_ex_mem_read  (bif.i_ex_mem_read),
        .i_ex_rd        (bif.i_ex_rd),
        .i_mem_mem_read (bif.i_mem_mem_read),
        .i_mem_rd       (bif.i_mem_rd),
        .o_need         (need)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        dir_d    = dir_q;
        taken_d  = taken_q;
        stalls_d = stalls_q;
        pc_write = 1'b0;
        pc_src   = 1'b0;
        stall    = 1'b0;
        flush    = 1'b0;
        bubble   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (need != 2'd0) begin
                    // Stall wins over a simultaneous taken decision; IDLE re-evaluates later.
                    stall    = 1'b1;
                    bubble   = 1'b1;
                    cnt_d    = need - 2'd1;
                    stalls_d = stalls_q + CW'(1);
                    if (need == 2'd2) state_d = ST_STALL;
                end else begin
                    pc_write = 1'b1;
                    if (bif.i_branch_control) begin
                        dir_d   = bif.i_branch_dir;
                        state_d = ST_REDIRECT;
                    end
                end
            end
            ST_STALL: begin
                stall    = 1'b1;
                bubble   = 1'b1;
                stalls_d = stalls_q + CW'(1);
                cnt_d    = (cnt_q != 2'd0) ? cnt_q - 2'd1 : 2'd0;
                if (cnt_q <= 2'd1) state_d = ST_IDLE;
            end
            ST_REDIRECT: begin
                // ID holds the wrong-path instruction, so its flag/decision are ignored.
                pc_write = 1'b1;
                pc_src   = 1'b1;
                flush    = 1'b1;
                bubble   = 1'b1;
                taken_d  = taken_q + CW'(1);
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (!bif.i_enable_etapa) begin
            state_d  = state_q;
            cnt_d    = cnt_q;
            dir_d    = dir_q;
            taken_d  = taken_q;
            stalls_d = stalls_q;
            pc_write = 1'b0;
            flush    = 1'b0;
            bubble   = 1'b0;
            stall    = 1'b1;
        end
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 2'd0;
            dir_q    <= '0;
            taken_q  <= '0;
            stalls_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            dir_q    <= dir_d;
            taken_q  <= taken_d;
            stalls_q <= stalls_d;
        end
    end

    // Strobes are quiet while reset is held, even though IDLE would otherwise load the PC.
    assign bif.o_pc_write            = i_reset & pc_write;
    assign bif.o_pc_src              = i_reset & pc_src;
    assign bif.o_stall               = i_reset & stall;
    assign bif.o_flush_if_id         = i_reset & flush;
    assign bif.o_bubble_id_ex        = i_reset & bubble;
    assign bif.o_pc_branch_dir       = dir_q;
    assign bif.o_cant_branches_taken = taken_q;
    assign bif.o_cant_stall_cycles   = stalls_q;

endmodule

// File: tb/tb_branch_control_unit.sv
// Directed bench for branch_control_unit: inputs set on negedge, outputs checked 1ns later.
module tb_branch_control_unit;
    import branch_pkg::*;

    localparam int AW = 11;
    localparam int FW = 3;
    localparam int RW = 5;
    localparam int CW = 16;

    logic clk = 1'b0;
    logic rst_n;
    int   n_assert = 0;
    int   n_fail   = 0;

    branch_control_unit_if #(
        .CANT_BITS_ADDR(AW), .CANT_BITS_FLAG_BRANCH(FW),
        .CANT_BITS_DIR_REGISTROS(RW), .CANT_BITS_CONTADOR(CW)
    ) bif ();

    branch_control_unit #(
        .CANT_BITS_ADDR(AW), .CANT_BITS_FLAG_BRANCH(FW),
        .CANT_BITS_DIR_REGISTROS(RW), .CANT_BITS_CONTADOR(CW)
    ) dut (
        .i_clock (clk),
        .i_reset (rst_n),
        .bif     (bif)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected end of test");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic strobes(input string tag, input logic pw, input logic src,
                           input logic stl, input logic fl, input logic bub);
        chk({tag, ".pc_write"}, 32'(bif.o_pc_write),     32'(pw));
        chk({tag, ".pc_src"},   32'(bif.o_pc_src),       32'(src));
        chk({tag, ".stall"},    32'(bif.o_stall),        32'(stl));
        chk({tag, ".flush"},    32'(bif.o_flush_if_id),  32'(fl));
        chk({tag, ".bubble"},   32'(bif.o_bubble_id_ex), 32'(bub));
    endtask

    task automatic clear_in();
        bif.i_flag_branch    = FW'(FLAG_NONE);
        bif.i_branch_control = 1'b0;
        bif.i_branch_dir     = '0;
        bif.i_rs             = '0;
        bif.i_rt             = '0;
        bif.i_ex_reg_write   = 1'b0;
        bif.i_ex_mem_read    = 1'b0;
        bif.i_ex_rd          = '0;
        bif.i_mem_mem_read   = 1'b0;
        bif.i_mem_rd         = '0;
    endtask

    task automatic next();
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        bif.i_enable_etapa = 1'b1;
        clear_in();
        #12;
        strobes("reset", 0, 0, 0, 0, 0);
        chk("reset.dir",    32'(bif.o_pc_branch_dir), 32'h0);
        chk("reset.taken",  32'(bif.o_cant_branches_taken), 32'h0);
        chk("reset.stalls", 32'(bif.o_cant_stall_cycles), 32'h0);

        next(); rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1 strobes("idle", 1, 0, 0, 0, 0);
            next();
        end
        chk("idle.taken",  32'(bif.o_cant_branches_taken), 32'h0);
        chk("idle.stalls", 32'(bif.o_cant_stall_cycles), 32'h0);

        // BEQ taken, no hazard
        bif.i_flag_branch = FW'(FLAG_BEQ); bif.i_rs = 5'd1; bif.i_rt = 5'd2;
        bif.i_branch_control = 1'b1; bif.i_branch_dir = 11'h040;
        #1 strobes("beq_eval", 1, 0, 0, 0, 0);
        next(); clear_in();
        #1 strobes("beq_redir", 1, 1, 0, 1, 1);
        chk("beq_redir.dir",   32'(bif.o_pc_branch_dir), 32'h040);
        chk("beq_redir.taken", 32'(bif.o_cant_branches_taken), 32'h0);
        next();
        #1 strobes("beq_after", 1, 0, 0, 0, 0);
        chk("beq_after.taken", 32'(bif.o_cant_branches_taken), 32'h1);

        // BNE load-use on rs: two stall cycles
        next();
        bif.i_flag_branch = FW'(FLAG_BNE); bif.i_rs = 5'd5; bif.i_rt = 5'd6;
        bif.i_ex_mem_read = 1'b1; bif.i_ex_reg_write = 1'b1; bif.i_ex_rd = 5'd5;
        bif.i_branch_control = 1'b1; bif.i_branch_dir = 11'h100;
        #1 strobes("lu_s1", 0, 0, 1, 0, 1);
        chk("lu_s1.stalls", 32'(bif.o_cant_stall_cycles), 32'h0);
        next();
        bif.i_ex_mem_read = 1'b0; bif.i_ex_reg_write = 1'b0; bif.i_ex_rd = '0;
        bif.i_mem_mem_read = 1'b1; bif.i_mem_rd = 5'd5;
        #1 strobes("lu_s2", 0, 0, 1, 0, 1);
        chk("lu_s2.stalls", 32'(bif.o_cant_stall_cycles), 32'h1);
        next();
        bif.i_mem_mem_read = 1'b0; bif.i_mem_rd = '0; bif.i_branch_control = 1'b0;
        #1 strobes("lu_eval", 1, 0, 0, 0, 0);
        chk("lu_eval.stalls", 32'(bif.o_cant_stall_cycles), 32'h2);

        // JR on r0 never hazards
        next(); clear_in();
        bif.i_flag_branch = FW'(FLAG_JR); bif.i_rs = 5'd0;
        bif.i_ex_reg_write = 1'b1; bif.i_ex_mem_read = 1'b1; bif.i_ex_rd = 5'd0;
        #1 strobes("jr_r0", 1, 0, 0, 0, 0);

        // ALU dependency on rt together with taken: stall first, then redirect
        next(); clear_in();
        bif.i_flag_branch = FW'(FLAG_BEQ); bif.i_rs = 5'd4; bif.i_rt = 5'd7;
        bif.i_ex_reg_write = 1'b1; bif.i_ex_rd = 5'd7;
        bif.i_branch_control = 1'b1; bif.i_branch_dir = 11'h3FF;
        #1 strobes("alu_stall", 0, 0, 1, 0, 1);
        chk("alu_stall.stalls", 32'(bif.o_cant_stall_cycles), 32'h2);
        next();
        bif.i_ex_reg_write = 1'b0; bif.i_ex_rd = '0; bif.i_branch_dir = 11'h123;
        #1 strobes("alu_eval", 1, 0, 0, 0, 0);
        chk("alu_eval.stalls", 32'(bif.o_cant_stall_cycles), 32'h3);
        next(); clear_in();
        bif.i_flag_branch = FW'(FLAG_JR); bif.i_rs = 5'd1;
        bif.i_branch_control = 1'b1; bif.i_branch_dir = 11'h3FF;
        #1 strobes("wp_redir", 1, 1, 0, 1, 1);
        chk("wp_redir.dir", 32'(bif.o_pc_branch_dir), 32'h123);
        next(); clear_in();
        #1 strobes("wp_after", 1, 0, 0, 0, 0);
        chk("wp_after.taken", 32'(bif.o_cant_branches_taken), 32'h2);
        chk("wp_after.dir",   32'(bif.o_pc_branch_dir), 32'h123);

        // Load in MEM: one stall cycle
        next();
        bif.i_flag_branch = FW'(FLAG_BEQ); bif.i_rs = 5'd9;
        bif.i_mem_mem_read = 1'b1; bif.i_mem_rd = 5'd9;
        #1 strobes("mem_stall", 0, 0, 1, 0, 1);
        next(); clear_in();
        #1 strobes("mem_eval", 1, 0, 0, 0, 0);
        chk("mem_eval.stalls", 32'(bif.o_cant_stall_cycles), 32'h4);

        // Enable dropped during STALL
        next();
        bif.i_flag_branch = FW'(FLAG_BNE); bif.i_rs = 5'd3;
        bif.i_ex_mem_read = 1'b1; bif.i_ex_reg_write = 1'b1; bif.i_ex_rd = 5'd3;
        #1 strobes("en_s1", 0, 0, 1, 0, 1);
        next();
        bif.i_ex_mem_read = 1'b0; bif.i_ex_reg_write = 1'b0; bif.i_ex_rd = '0;
        bif.i_enable_etapa = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1 strobes("en_off", 0, 0, 1, 0, 0);
            chk("en_off.stalls", 32'(bif.o_cant_stall_cycles), 32'h5);
            next();
        end
        bif.i_enable_etapa = 1'b1;
        #1 strobes("en_s2", 0, 0, 1, 0, 1);
        chk("en_s2.stalls", 32'(bif.o_cant_stall_cycles), 32'h5);
        next();
        #1 strobes("en_eval", 1, 0, 0, 0, 0);
        chk("en_eval.stalls", 32'(bif.o_cant_stall_cycles), 32'h6);

        // Reset during REDIRECT aborts the redirect
        next(); clear_in();
        bif.i_flag_branch = FW'(FLAG_BEQ); bif.i_rs = 5'd1; bif.i_rt = 5'd2;
        bif.i_branch_control = 1'b1; bif.i_branch_dir = 11'h055;
        #1 strobes("rr_eval", 1, 0, 0, 0, 0);
        next(); clear_in();
        #1 strobes("rr_redir", 1, 1, 0, 1, 1);
        chk("rr_redir.dir", 32'(bif.o_pc_branch_dir), 32'h055);
        #1 rst_n = 1'b0;
        #1 strobes("rr_reset", 0, 0, 0, 0, 0);
        chk("rr_reset.dir",    32'(bif.o_pc_branch_dir), 32'h0);
        chk("rr_reset.taken",  32'(bif.o_cant_branches_taken), 32'h0);
        chk("rr_reset.stalls", 32'(bif.o_cant_stall_cycles), 32'h0);
        next(); rst_n = 1'b1;
        #1 strobes("rr_after", 1, 0, 0, 0, 0);
        next();
        #1 strobes("rr_after2", 1, 0, 0, 0, 0);
        chk("rr_after2.taken", 32'(bif.o_cant_branches_taken), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
